// File: rtl/fir_serial_mac_ctrl.sv
// Streaming 8-tap FIR controller: one shared multiply-accumulate walks the taps,
// one per cycle, between a valid/ready sample source and a valid/ready result sink.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a sample; coefficient writes are accepted here
// MAC    | accumulating tap[idx]*coeff[idx], exactly TAPS cycles
// OUT    | result held on out_data until the sink takes it
module fir_serial_mac_ctrl #(
    parameter int DATA_W  = 8,
    parameter int COEFF_W = 8,
    parameter int TAPS    = 8,
    parameter int OUT_W   = 16,
    parameter int IDX_W   = $clog2(TAPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [COEFF_W-1:0] cfg_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               busy
);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ACC_W  = PROD_W + IDX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]         state;
    logic [DATA_W-1:0]  tap   [TAPS];
    logic [COEFF_W-1:0] coeff [TAPS];
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic [PROD_W-1:0]  prod;
    logic [IDX_W-1:0]   idx;
    logic               accept;
    logic               last_tap;
    logic               cfg_wr_en;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_MAC) || (state == S_OUT);
    assign out_valid = (state == S_OUT);
    assign accept    = in_valid && in_ready;
    assign last_tap  = (idx == IDX_W'(TAPS - 1));
    assign cfg_wr_en = cfg_we && (state == S_IDLE);

    assign prod    = PROD_W'(tap[idx]) * PROD_W'(coeff[idx]);
    assign acc_sum = acc + ACC_W'(prod);

    // Coefficient bank; writes outside IDLE are dropped so a running MAC never sees a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                coeff[k] <= COEFF_W'(k + 1);
            end
        end else if (cfg_wr_en) begin
            for (int k = 0; k < TAPS; k++) begin
                if (cfg_addr == IDX_W'(k)) begin
                    coeff[k] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                tap[k] <= '0;
            end
        end else if (accept) begin
            tap[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
                tap[k] <= tap[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            acc      <= '0;
            idx      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc_sum;
                    idx <= idx + IDX_W'(1);
                    if (last_tap) begin
                        out_data <= acc_sum[OUT_W-1:0];
                        state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_serial_mac_ctrl.sv
// Self-checking bench for fir_serial_mac_ctrl: table vectors, corner sequences,
// and randomized traffic against an arithmetic FIR model.
module tb_fir_serial_mac_ctrl;
    localparam int TAPS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int m_hist  [TAPS];
    int m_coeff [TAPS];

    typedef struct {
        int sample;
        int hold;
        int expv;
    } vec_t;

    vec_t vecs [17];

    fir_serial_mac_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_hist[k]  = 0;
            m_coeff[k] = k + 1;
        end
    endtask

    function automatic int model_out();
        int s = 0;
        for (int k = 0; k < TAPS; k++) s += m_hist[k] * m_coeff[k];
        return s % 65536;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cfg_write(input int addr, input int data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr[2:0]; cfg_data = data[7:0];
        @(negedge clk);
        cfg_we = 1'b0;
        m_coeff[addr] = data;
    endtask

    // wmode: 0 no write, 1 write in the accept cycle, 2 write held through MAC
    task automatic run_sample(input int d, input int hold, input int wmode,
                              input int waddr, input int wdata, input int exp_fixed);
        int n;
        int lat;
        int expv;
        int got;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_data = d[7:0];
        in_valid = 1'b1;
        if (wmode == 1) begin
            cfg_we = 1'b1; cfg_addr = waddr[2:0]; cfg_data = wdata[7:0];
        end
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b0;
        if (wmode == 1) m_coeff[waddr] = wdata;
        for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = d;
        expv = model_out();
        check("busy_in_mac", busy, 1);
        check("in_ready_in_mac", in_ready, 0);
        if (wmode == 2) begin
            cfg_we = 1'b1; cfg_addr = waddr[2:0]; cfg_data = wdata[7:0];
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!out_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        // Accept edge is edge 1; out_valid follows TAPS further edges.
        check("latency_edges", lat, TAPS);
        got = int'(out_data);
        check("out_data_model", got, expv);
        if (exp_fixed >= 0) check("out_data_table", got, exp_fixed);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, got);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_handshake_valid", out_valid, 0);
        check("post_handshake_ready", in_ready, 1);
    endtask

    initial begin
        int seen;
        model_reset();
        do_reset();

        // Impulse then full-scale step, default coefficients.
        vecs[0] = '{1, 0, 1};
        for (int i = 1; i <= 8; i++) vecs[i] = '{0, i % 3, (i < 8) ? i + 1 : 0};
        for (int i = 1; i <= 8; i++) vecs[8 + i] = '{255, i % 2, 255 * i * (i + 1) / 2};
        for (int i = 0; i < 17; i++) begin
            run_sample(vecs[i].sample, vecs[i].hold, 0, 0, 0, vecs[i].expv);
        end

        // Wrap: all coefficients full scale.
        for (int k = 0; k < TAPS; k++) cfg_write(k, 255);
        for (int i = 0; i < 8; i++) run_sample(255, 0, 0, 0, 0, (i == 7) ? 61448 : -1);

        // Backpressure for 5 cycles in OUT.
        run_sample(3, 5, 0, 0, 0, -1);

        // Config gating: write during MAC is dropped, in IDLE it applies.
        do_reset();
        run_sample(1, 0, 2, 0, 9, 1);
        do_reset();
        cfg_write(0, 9);
        run_sample(1, 0, 0, 0, 0, 9);
        do_reset();
        run_sample(1, 1, 1, 0, 5, 5);

        // Reset in the middle of MAC.
        do_reset();
        run_sample(50, 0, 0, 0, 0, 50);
        @(negedge clk);
        in_data = 8'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midmac_busy_before", busy, 1);
        rst_n = 1'b0;
        #2;
        check("midmac_rst_valid", out_valid, 0);
        check("midmac_rst_busy", busy, 0);
        check("midmac_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midmac_no_valid_pulse", seen, 0);
        run_sample(1, 0, 0, 0, 0, 1);
        run_sample(0, 0, 0, 0, 0, 2);
        run_sample(0, 0, 0, 0, 0, 3);

        // Randomized traffic with interleaved coefficient writes.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, 7), $urandom_range(0, 255));
            run_sample($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 2),
                       $urandom_range(0, 7), $urandom_range(0, 255), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
